// File: rtl/ask_demodulator.sv
// ASK demodulator: per-window peak envelope, level slicing and
// MSB-first serialisation of the recovered symbol for 2/4/8ASK.
module ask_demodulator #(
    parameter int SAMPLE_W   = 8,
    parameter int BIT_CYCLES = 5000,
    parameter int GUARD      = 100,
    parameter int FULL_SCALE = 200,
    parameter int OFFSET     = 0
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [1:0]          i_mode,
    input  logic                i_sync,
    input  logic [SAMPLE_W-1:0] i_adc_in,
    output logic [2:0]          o_sym_out,
    output logic                o_sym_valid,
    output logic                o_bit_out,
    output logic                o_bit_valid,
    output logic [SAMPLE_W-1:0] o_peak_out
);

    localparam int CNT_W = $clog2(3 * BIT_CYCLES);

    typedef logic [CNT_W-1:0]  cnt_t;
    typedef logic [SAMPLE_W:0] thr_t;
    typedef enum logic {IDLE, ACQ} state_t;

    localparam cnt_t LAST1   = cnt_t'(BIT_CYCLES - 1);
    localparam cnt_t LAST2   = cnt_t'(2 * BIT_CYCLES - 1);
    localparam cnt_t LAST3   = cnt_t'(3 * BIT_CYCLES - 1);
    localparam cnt_t GUARD_C = cnt_t'(GUARD);
    localparam thr_t OFF_W   = thr_t'(OFFSET);
    localparam thr_t NONE    = '1;

    function automatic thr_t thr(input int l, input int j);
        int t;
        t = ((2 * j - 1) * FULL_SCALE) / (2 * (l - 1));
        if (t > (1 << (SAMPLE_W + 1)) - 1) t = (1 << (SAMPLE_W + 1)) - 1;
        return thr_t'(t);
    endfunction

    // Row = mode; unused slots can never be reached by a SAMPLE_W peak.
    localparam thr_t THR [4][7] = '{
        '{NONE, NONE, NONE, NONE, NONE, NONE, NONE},
        '{thr(2, 1), NONE, NONE, NONE, NONE, NONE, NONE},
        '{thr(4, 1), thr(4, 2), thr(4, 3), NONE, NONE, NONE, NONE},
        '{thr(8, 1), thr(8, 2), thr(8, 3), thr(8, 4),
          thr(8, 5), thr(8, 6), thr(8, 7)}
    };

    state_t              r_state;
    logic [1:0]          r_mode_q;
    cnt_t                r_cnt;
    logic [SAMPLE_W-1:0] r_peak;
    logic [1:0]          r_sh;
    logic [1:0]          r_sh_cnt;
    logic [2:0]          r_sym_out;
    logic                r_sym_valid;
    logic                r_bit_out;
    logic                r_bit_valid;
    logic [SAMPLE_W-1:0] r_peak_out;

    logic [SAMPLE_W:0]   w_diff;
    logic [SAMPLE_W-1:0] w_amp;
    logic [SAMPLE_W-1:0] w_final;
    logic [2:0]          w_level;
    cnt_t                w_last;
    logic                w_msb;
    logic [1:0]          w_sh;
    logic [1:0]          w_nsh;

    assign w_diff = {1'b0, i_adc_in} - OFF_W;
    assign w_amp  = w_diff[SAMPLE_W] ? '0 : w_diff[SAMPLE_W-1:0];

    always_comb begin
        if (r_cnt == GUARD_C)
            w_final = w_amp;
        else if (r_cnt > GUARD_C)
            w_final = (w_amp > r_peak) ? w_amp : r_peak;
        else
            w_final = r_peak;
    end

    always_comb begin
        w_level = '0;
        for (int j = 0; j < 7; j++)
            if ({1'b0, w_final} >= THR[r_mode_q][j])
                w_level = w_level + 3'd1;
    end

    always_comb begin
        w_last = LAST1;
        w_msb  = w_level[0];
        w_sh   = 2'b00;
        w_nsh  = 2'd0;
        case (r_mode_q)
            2'b10: begin
                w_last = LAST2;
                w_msb  = w_level[1];
                w_sh   = {w_level[0], 1'b0};
                w_nsh  = 2'd1;
            end
            2'b11: begin
                w_last = LAST3;
                w_msb  = w_level[2];
                w_sh   = w_level[1:0];
                w_nsh  = 2'd2;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_mode_q    <= 2'b00;
            r_cnt       <= '0;
            r_peak      <= '0;
            r_sh        <= 2'b00;
            r_sh_cnt    <= 2'd0;
            r_sym_out   <= 3'd0;
            r_sym_valid <= 1'b0;
            r_bit_out   <= 1'b0;
            r_bit_valid <= 1'b0;
            r_peak_out  <= '0;
        end else begin
            r_mode_q    <= i_mode;
            r_sym_valid <= 1'b0;
            if (r_sh_cnt != 2'd0) begin
                r_bit_out   <= r_sh[1];
                r_sh        <= {r_sh[0], 1'b0};
                r_sh_cnt    <= r_sh_cnt - 2'd1;
                r_bit_valid <= 1'b1;
            end else begin
                r_bit_valid <= 1'b0;
            end

            if (i_mode == 2'b00) begin
                r_state     <= IDLE;
                r_cnt       <= '0;
                r_peak      <= '0;
                r_sh_cnt    <= 2'd0;
                r_sym_out   <= 3'd0;
                r_bit_out   <= 1'b0;
                r_bit_valid <= 1'b0;
                r_peak_out  <= '0;
            end else if (r_state == IDLE || i_mode != r_mode_q) begin
                // New or changed mode: restart the window, drop any bits
                r_state     <= ACQ;
                r_cnt       <= '0;
                r_peak      <= '0;
                r_sh_cnt    <= 2'd0;
                r_bit_valid <= 1'b0;
            end else if (i_sync) begin
                r_cnt  <= '0;
                r_peak <= '0;
            end else begin
                r_peak <= w_final;
                if (r_cnt == w_last) begin
                    r_cnt       <= '0;
                    r_sym_out   <= w_level;
                    r_peak_out  <= w_final;
                    r_sym_valid <= 1'b1;
                    r_bit_out   <= w_msb;
                    r_bit_valid <= 1'b1;
                    r_sh        <= w_sh;
                    r_sh_cnt    <= w_nsh;
                end else begin
                    r_cnt <= r_cnt + cnt_t'(1);
                end
            end
        end
    end

    assign o_sym_out   = r_sym_out;
    assign o_sym_valid = r_sym_valid;
    assign o_bit_out   = r_bit_out;
    assign o_bit_valid = r_bit_valid;
    assign o_peak_out  = r_peak_out;

endmodule

// File: tb/tb_ask_demodulator.sv
// Directed bench for ask_demodulator; shortened bit period keeps the run
// small while thresholds and guard stay at their nominal values.
module tb_ask_demodulator;

    localparam int B = 1000;

    logic       clk = 1'b0;
    logic       i_rst = 1'b1;
    logic [1:0] i_mode = 2'b00;
    logic       i_sync = 1'b0;
    logic [7:0] i_adc_in = 8'd0;
    logic [2:0] o_sym_out;
    logic       o_sym_valid;
    logic       o_bit_out;
    logic       o_bit_valid;
    logic [7:0] o_peak_out;

    ask_demodulator #(
        .SAMPLE_W(8), .BIT_CYCLES(B), .GUARD(100),
        .FULL_SCALE(200), .OFFSET(0)
    ) dut (
        .i_clk(clk), .i_rst(i_rst), .i_mode(i_mode), .i_sync(i_sync),
        .i_adc_in(i_adc_in), .o_sym_out(o_sym_out),
        .o_sym_valid(o_sym_valid), .o_bit_out(o_bit_out),
        .o_bit_valid(o_bit_valid), .o_peak_out(o_peak_out)
    );

    always #10 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int sq[$], sc[$], bq[$], bc[$];

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int qget(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    function automatic int pack(input int q[$]);
        int v = 0;
        foreach (q[i]) v = (v << 1) | q[i];
        return v;
    endfunction

    task automatic clr();
        sq.delete(); sc.delete(); bq.delete(); bc.delete();
    endtask

    // One sample per clock; strobes logged just after each edge.
    task automatic feed(input int n, input int a);
        for (int i = 0; i < n; i++) begin
            i_adc_in = 8'(a);
            @(posedge clk);
            #1;
            cyc++;
            if (o_sym_valid) begin
                sq.push_back(int'(o_sym_out));
                sc.push_back(cyc);
            end
            if (o_bit_valid) begin
                bq.push_back(int'(o_bit_out));
                bc.push_back(cyc);
            end
        end
    endtask

    int c0, cm, sm, rm;
    int amps4 [4] = '{0, 67, 133, 200};

    initial begin
        feed(2, 0);
        check_eq("rst_sym", int'(o_sym_out), 0);
        check_eq("rst_symv", int'(o_sym_valid), 0);
        check_eq("rst_bitv", int'(o_bit_valid), 0);
        check_eq("rst_bit", int'(o_bit_out), 0);
        check_eq("rst_peak", int'(o_peak_out), 0);
        i_rst = 1'b0;

        clr();
        feed(50, 200);
        check_eq("idle_syms", sq.size(), 0);
        check_eq("idle_bits", bq.size(), 0);
        check_eq("idle_peak", int'(o_peak_out), 0);

        // 2ASK
        i_mode = 2'b01;
        feed(1, 0);
        clr();
        feed(B, 180);
        c0 = cyc;
        check_eq("2a_n", sq.size(), 1);
        check_eq("2a_sym0", qget(sq, 0), 1);
        check_eq("2a_lat", qget(sc, 0), c0);
        check_eq("2a_bit0", qget(bq, 0), 1);
        check_eq("2a_bitlat", qget(bc, 0), c0);
        check_eq("2a_peak0", int'(o_peak_out), 180);
        feed(B, 40);
        check_eq("2a_sym1", qget(sq, 1), 0);
        check_eq("2a_nbits", bq.size(), 2);
        check_eq("2a_bit1", qget(bq, 1), 0);
        check_eq("2a_peak1", int'(o_peak_out), 40);

        // 4ASK levels 0..3
        i_mode = 2'b10;
        feed(1, 0);
        clr();
        for (int w = 0; w < 4; w++) feed(2 * B, amps4[w]);
        feed(1, 0);
        check_eq("4a_n", sq.size(), 4);
        for (int w = 0; w < 4; w++) check_eq("4a_sym", qget(sq, w), w);
        check_eq("4a_nbits", bq.size(), 8);
        check_eq("4a_stream", pack(bq), 8'b00011011);
        check_eq("4a_b0cyc", qget(bc, 0), qget(sc, 0));
        check_eq("4a_b1cyc", qget(bc, 1), qget(sc, 0) + 1);

        // 8ASK peak 150 -> level 5
        i_mode = 2'b11;
        feed(1, 0);
        clr();
        feed(3 * B, 150);
        c0 = cyc;
        feed(2, 0);
        check_eq("8a_sym", qget(sq, 0), 5);
        check_eq("8a_lat", qget(sc, 0), c0);
        check_eq("8a_nbits", bq.size(), 3);
        check_eq("8a_stream", pack(bq), 3'b101);
        check_eq("8a_b2cyc", qget(bc, 2), c0 + 2);

        // Guard excludes the spike; threshold boundaries
        i_mode = 2'b10;
        feed(1, 0);
        clr();
        feed(100, 255);
        for (int i = 0; i < 2 * B - 100; i++) feed(1, (i % 13) * 5);
        check_eq("guard_sym", qget(sq, 0), 1);
        check_eq("guard_peak", int'(o_peak_out), 60);
        feed(2 * B, 100);
        check_eq("bnd100", qget(sq, 1), 2);
        feed(2 * B, 99);
        check_eq("bnd99", qget(sq, 2), 1);

        // Mode change mid-window, then abort of a pending shift
        feed(B, 200);
        i_mode = 2'b11;
        cm = cyc;
        clr();
        feed(3 * B + 1, 150);
        check_eq("mc_n", sq.size(), 1);
        check_eq("mc_lat", qget(sc, 0), cm + 3 * B + 1);
        check_eq("mc_sym", qget(sq, 0), 5);
        i_mode = 2'b10;
        clr();
        feed(1, 0);
        check_eq("mc_abort", int'(o_bit_valid), 0);
        check_eq("mc_nbits", bq.size(), 0);

        // sync realigns; sync on the last count suppresses the decision
        i_mode = 2'b01;
        feed(1, 0);
        clr();
        feed(B / 2, 180);
        i_sync = 1'b1;
        sm = cyc;
        feed(1, 180);
        i_sync = 1'b0;
        feed(B, 40);
        check_eq("sync_n", sq.size(), 1);
        check_eq("sync_lat", qget(sc, 0), sm + B + 1);
        check_eq("sync_sym", qget(sq, 0), 0);
        feed(B - 1, 180);
        i_sync = 1'b1;
        feed(1, 180);
        i_sync = 1'b0;
        check_eq("sync_last_n", sq.size(), 1);
        feed(B, 180);
        check_eq("sync_next_n", sq.size(), 2);
        check_eq("sync_next_sym", qget(sq, 1), 1);

        // Reset during shift
        i_mode = 2'b11;
        feed(1, 0);
        clr();
        feed(3 * B, 150);
        check_eq("rs_bitv_pre", int'(o_bit_valid), 1);
        i_rst = 1'b1;
        feed(1, 0);
        check_eq("rs_bitv", int'(o_bit_valid), 0);
        check_eq("rs_symv", int'(o_sym_valid), 0);
        check_eq("rs_sym", int'(o_sym_out), 0);
        check_eq("rs_peak", int'(o_peak_out), 0);
        i_rst = 1'b0;
        rm = cyc;
        clr();
        feed(3 * B + 3, 150);
        check_eq("rs_n", sq.size(), 1);
        check_eq("rs_lat", qget(sc, 0), rm + 3 * B + 1);
        check_eq("rs_nbits", bq.size(), 3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ask_demodulator.md
Name: ask_demodulator

Overview:
- Receive-side counterpart of the ASK modulator: takes digitised ASK samples and recovers the serial bit stream for 2ASK, 4ASK and 8ASK.
- Runs at the modulator clock rate (50 MHz, one sample per clock).
- For each symbol window, tracks the peak envelope, slices it to an amplitude level, and emits the symbol both in parallel and as serial bits, MSB first.
- Sits between the ADC capture register and the bit sink/BER checker.

Parameters:
- SAMPLE_W, 8: width of adc_in and of the internal peak register.
- BIT_CYCLES, 5000: clocks per transmitted bit. Symbol window = BIT_CYCLES * bits-per-symbol (1, 2 or 3).
- GUARD, 100: clocks at the start of each window excluded from peak tracking (transition/settling).
- FULL_SCALE, 200: amplitude of the maximum level (level L-1).
- OFFSET, 0: ADC code for zero amplitude.

Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  synchronous reset, active-high
- mode  in  2  00 off, 01 2ASK, 10 4ASK, 11 8ASK
- sync  in  1  one-cycle pulse that realigns the symbol window; the cycle after sync is count 0
- adc_in  in  SAMPLE_W  unsigned received sample, valid every clock
- sym_out  out  3  last decided level, zero-extended
- sym_valid  out  1  one-cycle strobe when sym_out updates
- bit_out  out  1  serial recovered bit
- bit_valid  out  1  strobe qualifying bit_out
- peak_out  out  SAMPLE_W  peak amplitude of the last window (debug)

Behaviour:
- Reset (rst=1 at posedge): counter=0, peak=0, state=IDLE, mode_q=0. All outputs are 0 on the next cycle.
- mode is registered into mode_q. Bits per symbol k: 1, 2 or 3 for mode_q 01, 10, 11. Levels L=2^k. Window N=k*BIT_CYCLES.
- Amplitude per sample: amp = adc_in - OFFSET, saturated to 0 when adc_in < OFFSET.
- States:
  - IDLE: entered when mode_q==00. Counter held at 0, no strobes. When mode_q becomes nonzero, go to ACQ with counter=0.
  - ACQ: counter runs 0..N-1 and wraps to 0.
    - Counter < GUARD: peak unchanged.
    - At counter==GUARD: peak loads amp.
    - Counter > GUARD: peak = max(peak, amp).
    - At counter==N-1: the final peak (including this sample) is latched to dec_peak, and DECIDE is flagged for the next cycle. Acquisition of the next window continues without a gap.
  - DECIDE (overlaps ACQ, one cycle):
    - level = number of thresholds T_j exceeded by dec_peak (amp >= T_j), where T_j = floor((2j-1)*FULL_SCALE / (2*(L-1))), j=1..L-1.
    - sym_out<=level, peak_out<=dec_peak, sym_valid<=1 for one cycle.
  - SHIFT:
    - MSB of level is driven on bit_out with bit_valid=1 in the same cycle as sym_valid.
    - The remaining k-1 bits follow on consecutive cycles, MSB to LSB.
    - bit_valid is high for exactly k consecutive cycles per symbol.
- Latency: sym_valid and the first bit_valid assert 1 cycle after the counter==N-1 sample.
- sync pulse: counter forced to 0 and peak cleared. A SHIFT already in progress completes. The truncated window produces no decision.
- sync and counter==N-1 in the same cycle: sync wins, no decision.
- mode_q change while nonzero:
  - Counter=0, peak=0, pending SHIFT aborted. bit_valid is 0 from the next cycle.
  - No decision for the interrupted window.
- rst mid-SHIFT: strobes deassert on the next cycle and no further bits are emitted.
- Arithmetic: threshold products are computed at elaboration using integer (floor) division. The peak comparator is SAMPLE_W wide, unsigned.

Test Plan:
- 2ASK, FULL_SCALE=200, T1=100: constant amplitude 180 for one window (5000 clk), then 40 -> sym_out 1 then 0; bit_out 1, 0; each with a 1-cycle bit_valid.
- 4ASK, thresholds 33/100/166: window peaks 0, 67, 133, 200 -> sym_out 0,1,2,3. Serial stream 00 01 10 11 MSB first, 2 consecutive bit_valid cycles per 10000-clk window.
- 8ASK, thresholds 14,42,71,100,128,157,185: peak 150 -> level 5. bit_out 1,0,1 on 3 consecutive cycles, 1 cycle after count 14999.
- Guard: 4ASK, spike of 255 during counter<100, sinusoid of peak 60 after -> level 1, not 3. Boundary: peak exactly 100 -> level 2.
- mode 10->11 mid-window -> no sym_valid for that window; next sym_valid exactly 15000+1 clocks after the change. mode 00 -> no strobes, all outputs 0.
- sync at count 2500 of a 2ASK window -> no decision for that window; next sym_valid 5001 clocks after sync. rst during SHIFT -> bit_valid 0 on the next cycle, and the next sym_valid comes a full window after rst release.
